// File: rtl/immgen_pkg.sv
// immgen_pkg: immediate format codes and decode function (IMMGEN_CSR_EN enables the Z format)
package immgen_pkg;
  typedef enum logic [2:0] {
    FMT_I = 3'd0,
    FMT_S = 3'd1,
    FMT_B = 3'd2,
    FMT_U = 3'd3,
    FMT_J = 3'd4,
    FMT_Z = 3'd5
  } imm_fmt_t;
  function automatic logic [64:0] imm_decode(input logic [24:0] f, input logic [2:0] fmt);
    logic [64:0] r;
    r = '0;
    case (fmt)
      FMT_I: r[63:0] = {{52{f[24]}}, f[24:13]};
      FMT_S: r[63:0] = {{52{f[24]}}, f[24:18], f[4:0]};
      FMT_B: r[63:0] = {{51{f[24]}}, f[24], f[0], f[23:18], f[4:1], 1'b0};
      FMT_U: r[63:0] = {{32{f[24]}}, f[24:5], 12'b0};
      FMT_J: r[63:0] = {{43{f[24]}}, f[24], f[12:5], f[13], f[23:14], 1'b0};
`ifdef IMMGEN_CSR_EN
      FMT_Z: r[63:0] = {59'd0, f[12:8]};
`endif
      default: r[64] = 1'b1;
    endcase
    return r;
  endfunction
endpackage

// File: rtl/immgen_core.sv
// immgen_core: combinational immediate extraction, instr/fmt in, imm/err out
import immgen_pkg::*;
module immgen_core #(
  parameter int DATA_WIDTH = 32
) (
  input  logic [24:0]           instr,
  input  logic [2:0]            fmt,
  output logic [DATA_WIDTH-1:0] imm,
  output logic                  err
);
  logic [64:0] d;
  assign d = imm_decode(instr, fmt);
  assign imm = DATA_WIDTH'(d[63:0]);
  assign err = d[64];
endmodule

// File: rtl/immgen_pipe.sv
// immgen_pipe: valid/ready immediate generator with output register and skid entry (IMMGEN_CSR_EN enables Z format)
module immgen_pipe #(
  parameter int DATA_WIDTH = 32,
  parameter int TAG_WIDTH  = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [24:0]           in_instr,
  input  logic [2:0]            in_fmt,
  input  logic [TAG_WIDTH-1:0]  in_tag,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_imm,
  output logic [TAG_WIDTH-1:0]  out_tag,
  output logic                  out_err
);
  logic [DATA_WIDTH-1:0] imm, skid_imm;
  logic [TAG_WIDTH-1:0]  skid_tag;
  logic                  err, skid_err, skid_full, in_fire, ld;
  immgen_core #(.DATA_WIDTH(DATA_WIDTH)) u_core (
    .instr(in_instr),
    .fmt  (in_fmt),
    .imm  (imm),
    .err  (err)
  );
  assign in_ready = !skid_full;
  assign in_fire  = in_valid && in_ready;
  assign ld       = !out_valid || out_ready;
  always_ff @(posedge clk)
    if (rst) begin
      out_valid <= 1'b0;
      skid_full <= 1'b0;
      out_imm   <= '0;
      out_tag   <= '0;
      out_err   <= 1'b0;
    end else if (ld) begin
      out_valid <= skid_full || in_fire;
      if (skid_full) begin
        out_imm   <= skid_imm;
        out_tag   <= skid_tag;
        out_err   <= skid_err;
        skid_full <= 1'b0;
      end else if (in_fire) begin
        out_imm <= imm;
        out_tag <= in_tag;
        out_err <= err;
      end
    end else if (in_fire) begin
      skid_full <= 1'b1;
      skid_imm  <= imm;
      skid_tag  <= in_tag;
      skid_err  <= err;
    end
endmodule
